// File: rtl/arb_pkg.sv
// Shared constants and state type for the 8-way priority arbiter.
package arb_pkg;

   localparam int unsigned NUM_REQ = 8;
   localparam int unsigned ID_W    = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

endpackage

// File: rtl/arb_prio_enc.sv
// Combinational 8-to-3 encoder: returns the highest-index asserted bit.
module arb_prio_enc
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_vec,
   output logic [ID_W-1:0]    idx,
   output logic               valid
);

   // Ascending scan; the last set bit seen (highest index) wins
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req_vec[i]) begin
            idx   = ID_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/priority_arbiter_8.sv
// 8-requester arbiter: fixed or round-robin priority, registered one-hot
// grant, optional hold limit with a timeout pulse on forced release.
module priority_arbiter_8
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               mode,
   output logic [NUM_REQ-1:0] gnt,
   output logic [ID_W-1:0]    gnt_id,
   output logic               gnt_valid,
   output logic               timeout
);

   localparam int unsigned      CNT_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '1;

   state_e             state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
   logic               timeout_q, timeout_d;
   logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [ID_W-1:0]    last_id_q, last_id_d;

   logic [ID_W-1:0]    rr_start;
   logic [NUM_REQ-1:0] rot_req;
   logic [NUM_REQ-1:0] enc_in;
   logic [ID_W-1:0]    enc_idx;
   logic               enc_valid;
   logic [ID_W-1:0]    win_id;

   // Rotate so the round-robin start index lands on bit 7; the shared
   // highest-index encoder then performs the descending, wrapping search
   always_comb begin
      rr_start = last_id_q - ID_W'(1);
      rot_req  = '0;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
         rot_req[j] = req[ID_W'(j) + rr_start + ID_W'(1)];
      end
      enc_in = mode ? rot_req : req;
   end

   arb_prio_enc u_enc (
      .req_vec (enc_in),
      .idx     (enc_idx),
      .valid   (enc_valid)
   );

   // Map the encoder result back to a real requester index
   always_comb begin
      win_id = mode ? (enc_idx + rr_start + ID_W'(1)) : enc_idx;
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         gnt_id_q   <= '0;
         timeout_q  <= 1'b0;
         hold_cnt_q <= '0;
         last_id_q  <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gnt_id_q   <= gnt_id_d;
         timeout_q  <= timeout_d;
         hold_cnt_q <= hold_cnt_d;
         last_id_q  <= last_id_d;
      end
   end

   // Next-state: arbitrate in IDLE, hold or release in GRANT
   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      gnt_id_d   = gnt_id_q;
      timeout_d  = 1'b0;
      hold_cnt_d = hold_cnt_q;
      last_id_d  = last_id_q;
      case (state_q)
         IDLE: begin
            gnt_d      = '0;
            gnt_id_d   = '0;
            hold_cnt_d = '0;
            if (enc_valid) begin
               state_d   = GRANT;
               gnt_d     = NUM_REQ'(1) << win_id;
               gnt_id_d  = win_id;
               last_id_d = win_id;
            end
         end
         GRANT: begin
            // A dropped request outranks the hold limit, so a coincident
            // release is treated as normal and raises no timeout
            if (!req[gnt_id_q]) begin
               state_d    = IDLE;
               gnt_d      = '0;
               gnt_id_d   = '0;
               hold_cnt_d = '0;
            end else if ((MAX_HOLD != 0) && (hold_cnt_q == CNT_MAX)) begin
               state_d    = IDLE;
               gnt_d      = '0;
               gnt_id_d   = '0;
               hold_cnt_d = '0;
               timeout_d  = 1'b1;
            end else if (hold_cnt_q != CNT_MAX) begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs come straight from registers
   always_comb begin
      gnt       = gnt_q;
      gnt_id    = gnt_id_q;
      gnt_valid = |gnt_q;
      timeout   = timeout_q;
   end

endmodule

// File: tb/tb_priority_arbiter_8.sv
// Directed self-checking bench for priority_arbiter_8 (MAX_HOLD = 4).
module tb_priority_arbiter_8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       mode;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   int n_cmp = 0;
   int n_err = 0;

   priority_arbiter_8 #(.MAX_HOLD(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .mode      (mode),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; sample 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
      check_eq("onehot", 32'($countones(gnt) <= 1), 32'd1);
   endtask

   task automatic expect_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_id,
                             input logic e_to);
      check_eq({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
      check_eq({tag, ".id"}, 32'(gnt_id), 32'(e_id));
      check_eq({tag, ".valid"}, 32'(gnt_valid), 32'(e_gnt != 8'd0));
      check_eq({tag, ".timeout"}, 32'(timeout), 32'(e_to));
   endtask

   initial begin
      logic [2:0] e;

      // Reset with every request asserted
      rst = 1'b1; req = 8'hFF; mode = 1'b0;
      tick(); tick();
      expect_out("rst", 8'h00, 3'd0, 1'b0);
      rst = 1'b0;
      tick();
      expect_out("post_rst", 8'h80, 3'd7, 1'b0);
      req = 8'h00;
      tick();
      expect_out("rel7", 8'h00, 3'd0, 1'b0);
      tick();
      expect_out("idle_noreq", 8'h00, 3'd0, 1'b0);

      // Fixed priority
      req = 8'b0101_0000;
      tick();
      expect_out("fix6", 8'h40, 3'd6, 1'b0);
      req = 8'b0001_0000;
      tick();
      expect_out("fix_bubble", 8'h00, 3'd0, 1'b0);
      tick();
      expect_out("fix4", 8'h10, 3'd4, 1'b0);
      req = 8'h00;
      tick();

      // Round-robin from a fresh reset: 7,6,...,0,7
      rst = 1'b1;
      tick();
      rst = 1'b0; mode = 1'b1; req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         e = 3'(7 - k);
         tick();
         expect_out($sformatf("rr%0d", k), 8'd1 << e, e, 1'b0);
         tick();
         expect_out($sformatf("rr%0d_hold", k), 8'd1 << e, e, 1'b0);
         req = 8'hFF & ~(8'd1 << e);
         tick();
         expect_out($sformatf("rr%0d_bubble", k), 8'h00, 3'd0, 1'b0);
         req = 8'hFF;
      end
      req = 8'h00;
      tick();

      // Forced release after 4 grant cycles, then re-grant in fixed mode
      mode = 1'b0; req = 8'h01;
      tick();
      expect_out("to_c0", 8'h01, 3'd0, 1'b0);
      for (int c = 1; c < 4; c++) begin
         tick();
         expect_out($sformatf("to_c%0d", c), 8'h01, 3'd0, 1'b0);
      end
      tick();
      expect_out("to_pulse", 8'h00, 3'd0, 1'b1);
      tick();
      expect_out("to_regrant", 8'h01, 3'd0, 1'b0);
      req = 8'h00;
      tick();
      expect_out("to_rel", 8'h00, 3'd0, 1'b0);

      // Coincident release at the limit edge: normal, no timeout
      req = 8'h02;
      tick();
      expect_out("co_c0", 8'h02, 3'd1, 1'b0);
      tick(); tick(); tick();
      expect_out("co_c3", 8'h02, 3'd1, 1'b0);
      req = 8'h00;
      tick();
      expect_out("co_rel", 8'h00, 3'd0, 1'b0);
      tick();
      expect_out("co_after", 8'h00, 3'd0, 1'b0);

      // Mode toggle during grant, then mid-grant reset
      mode = 1'b0; req = 8'h04;
      tick();
      expect_out("mg_grant", 8'h04, 3'd2, 1'b0);
      mode = 1'b1; req = 8'h84;
      tick();
      expect_out("mg_modechg", 8'h04, 3'd2, 1'b0);
      rst = 1'b1;
      tick();
      expect_out("mg_rst", 8'h00, 3'd0, 1'b0);
      // last_id cleared: RR search starts at 7, so bit 2 beats bit 1
      rst = 1'b0; req = 8'h06;
      tick();
      expect_out("mg_lastid", 8'h04, 3'd2, 1'b0);
      req = 8'h00;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/priority_arbiter_8.md
PRIORITY_ARBITER_8 -- requirements
Module: priority_arbiter_8

Interface
REQ-001 Parameter: MAX_HOLD, default 16, max consecutive grant cycles per requester; 0 disables the hold limit.
REQ-002 The block SHALL use one clock and a synchronous, active-high reset. Ports are listed below.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  8  per-requester request; bit i belongs to requester i.
REQ-006 mode  input  1  0 = fixed priority (bit 7 highest), 1 = round-robin.
REQ-007 gnt  output  8  one-hot grant; all-zero when no grant.
REQ-008 gnt_id  output  3  binary index of granted requester; 0 when gnt is all-zero.
REQ-009 gnt_valid  output  1  high iff gnt is non-zero.
REQ-010 timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-011 The block SHALL implement two states: IDLE (no grant) and GRANT (one requester owns the resource).
REQ-012 In IDLE with req != 0 at edge N, the block SHALL enter GRANT, and gnt/gnt_id/gnt_valid SHALL be valid after edge N (1-cycle registered latency).
REQ-013 In IDLE with req == 0, the block SHALL stay in IDLE with all outputs zero.
REQ-014 Fixed mode: the winner SHALL be the highest-index asserted req bit.
REQ-015 Round-robin mode: search SHALL start at index (last_id - 1) mod 8 and descend with wrap 0 -> 7; the first asserted bit wins.
REQ-016 last_id SHALL update to the winner on every grant in both modes.
REQ-017 mode SHALL be sampled only at the IDLE arbitration edge; changes during GRANT SHALL have no effect on the current grant.
REQ-018 In GRANT, the grant SHALL be held while req[gnt_id] = 1 and the hold limit has not been reached; other req bits SHALL be ignored.
REQ-019 hold_cnt SHALL be 0 on grant entry and increment each GRANT cycle, saturating at MAX_HOLD - 1.
REQ-020 Normal release: when req[gnt_id] = 0 at an edge in GRANT, the block SHALL return to IDLE and outputs SHALL clear after that edge; timeout SHALL stay 0.
REQ-021 Forced release (MAX_HOLD > 0): at the edge where hold_cnt = MAX_HOLD - 1 and req[gnt_id] = 1, the block SHALL return to IDLE and pulse timeout for exactly the following cycle.
REQ-022 Every release SHALL produce exactly one IDLE cycle with gnt = 0 (bubble) before any new grant.
REQ-023 If normal and forced release conditions coincide, the release SHALL be normal, with timeout = 0.
REQ-024 In fixed mode, a timed-out requester SHALL be re-granted after the bubble if it is still the highest asserted requester (starvation accepted in fixed mode).
REQ-025 gnt SHALL never have more than one bit set.

Reset
REQ-026 While rst = 1 at an edge: state = IDLE; gnt = 0; gnt_id = 0; gnt_valid = 0; timeout = 0; hold_cnt = 0; last_id = 0.
REQ-027 Reset asserted mid-grant SHALL drop the grant after that edge; reset SHALL take priority over all other conditions.
REQ-028 The first arbitration after reset SHALL therefore start its round-robin search at index 7, matching fixed priority.

Structure
REQ-029 Package arb_pkg SHALL hold NUM_REQ = 8, ID_W = 3, and the state enum {IDLE, GRANT}.
REQ-030 One combinational sub-module, arb_prio_enc, SHALL provide an 8-to-3 highest-index encoder with a valid flag.
REQ-031 Round-robin mode SHALL rotate req by the search start index, apply arb_prio_enc, then rotate the result index back.

Verification
REQ-032 Reset: rst = 1 with req = 8'hFF -> all outputs 0; release rst -> gnt_id = 7 one cycle later.
REQ-033 Fixed priority: mode = 0, req = 8'b0101_0000 -> gnt = 8'b0100_0000, gnt_id = 6; drop req[6] -> one bubble cycle, then gnt_id = 4.
REQ-034 Round-robin: mode = 1, req = 8'hFF, each grant released after 2 cycles -> gnt_id sequence 7, 6, 5, ..., 0, 7, with a bubble between grants.
REQ-035 Timeout: MAX_HOLD = 4, req = 8'b0000_0001 held -> gnt high for 4 cycles, then timeout pulses 1 cycle with gnt = 0, then re-grant to 0.
REQ-036 Coincident release: MAX_HOLD = 4, req[gnt_id] dropped at the 4th grant edge -> timeout stays 0.
REQ-037 Mid-grant reset and mode change: mode toggled during GRANT -> current grant unaffected; rst pulsed during GRANT -> gnt = 0 next cycle and last_id = 0.
